// File: rtl/w4a8_stream_mac.sv
// W4A8 multi-lane dot-product stage: int8 activations x int4 weights, accumulated per lane
// over k_beats input beats, one output beat of C_LANES accumulators per group.
module w4a8_stream_mac #(
  parameter int C_LANES      = 8,
  parameter int C_K_PAR      = 16,
  parameter int C_ACC_WIDTH  = 32,
  parameter int C_KCNT_WIDTH = 16,
  parameter int C_OCNT_WIDTH = 32
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  input  logic                           ctrl_start,
  input  logic [C_KCNT_WIDTH-1:0]        ctrl_k_beats,
  input  logic [C_OCNT_WIDTH-1:0]        ctrl_num_outputs,
  input  logic                           ctrl_saturate,
  output logic                           ctrl_done,
  output logic                           ctrl_busy,
  input  logic                           s_act_tvalid,
  output logic                           s_act_tready,
  input  logic [8*C_K_PAR-1:0]           s_act_tdata,
  input  logic                           s_wgt_tvalid,
  output logic                           s_wgt_tready,
  input  logic [4*C_LANES*C_K_PAR-1:0]   s_wgt_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [C_ACC_WIDTH*C_LANES-1:0] m_axis_tdata,
  output logic                           m_axis_tlast
);
  localparam int W = C_ACC_WIDTH;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [C_KCNT_WIDTH-1:0] k_beats_q, k_cnt_q;
  logic [C_OCNT_WIDTH-1:0] num_out_q, grp_cnt_q, out_cnt_q;
  logic                    sat_q;
  logic                    p1_valid_q, p1_last_q, m_valid_q;
  logic                    en, accept, grp_last, job_last, out_hs;

  // Two's-complement add that either wraps or clamps to the signed range of W bits.
  function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sat);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (sat && (s[W] != s[W-1]))
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  assign en            = !m_valid_q || m_axis_tready;
  assign s_act_tready  = (state_q == S_RUN) && en;
  assign s_wgt_tready  = s_act_tready;
  assign accept        = s_act_tready && s_act_tvalid && s_wgt_tvalid;
  assign grp_last      = (k_cnt_q == k_beats_q - C_KCNT_WIDTH'(1));
  assign job_last      = grp_last && (grp_cnt_q == num_out_q - C_OCNT_WIDTH'(1));
  assign out_hs        = m_valid_q && m_axis_tready;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_valid_q && (out_cnt_q == num_out_q - C_OCNT_WIDTH'(1));
  assign ctrl_done     = (state_q == S_DONE);
  assign ctrl_busy     = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ctrl_start) state_d = (ctrl_num_outputs == '0) ? S_DONE : S_RUN;
      S_RUN:   if (accept && job_last) state_d = S_DRAIN;
      S_DRAIN: if (out_hs && m_axis_tlast) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      k_beats_q  <= '0;
      num_out_q  <= '0;
      sat_q      <= 1'b0;
      k_cnt_q    <= '0;
      grp_cnt_q  <= '0;
      out_cnt_q  <= '0;
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ctrl_start) begin
        k_beats_q <= (ctrl_k_beats == '0) ? C_KCNT_WIDTH'(1) : ctrl_k_beats;
        num_out_q <= ctrl_num_outputs;
        sat_q     <= ctrl_saturate;
        k_cnt_q   <= '0;
        grp_cnt_q <= '0;
        out_cnt_q <= '0;
      end
      if (accept) begin
        if (grp_last) begin
          k_cnt_q   <= '0;
          grp_cnt_q <= grp_cnt_q + C_OCNT_WIDTH'(1);
        end else begin
          k_cnt_q   <= k_cnt_q + C_KCNT_WIDTH'(1);
        end
      end
      if (out_hs) out_cnt_q <= out_cnt_q + C_OCNT_WIDTH'(1);
      // Pipeline flags advance only when the output side can move.
      if (en) begin
        p1_valid_q <= accept;
        p1_last_q  <= accept && grp_last;
        m_valid_q  <= p1_valid_q && p1_last_q;
      end
    end
  end

  for (genvar gl = 0; gl < C_LANES; gl++) begin : g_lane
    logic signed [11:0] prod;
    logic [W-1:0]       lane_sum;
    logic [W-1:0]       partial_q, acc_q, out_q;

    always_comb begin
      prod     = '0;
      lane_sum = '0;
      for (int k = 0; k < C_K_PAR; k++) begin
        prod = $signed({{4{s_act_tdata[8*k+7]}}, s_act_tdata[8*k +: 8]})
             * $signed({{8{s_wgt_tdata[4*(gl*C_K_PAR+k)+3]}}, s_wgt_tdata[4*(gl*C_K_PAR+k) +: 4]});
        lane_sum = lane_sum + {{(W-12){prod[11]}}, prod};
      end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
        partial_q <= '0;
        acc_q     <= '0;
        out_q     <= '0;
      end else if (en) begin
        if (accept) partial_q <= lane_sum;
        if (p1_valid_q) begin
          if (p1_last_q) begin
            out_q <= acc_add(acc_q, partial_q, sat_q);
            acc_q <= '0;
          end else begin
            acc_q <= acc_add(acc_q, partial_q, sat_q);
          end
        end
      end
    end

    assign m_axis_tdata[W*gl +: W] = out_q;
  end
endmodule

// File: tb/tb_w4a8_stream_mac.sv
// Self-checking bench for w4a8_stream_mac: integer reference model feeds a scoreboard,
// an independent monitor checks every output beat, done pulses and stall stability.
`timescale 1ns/1ps
module tb_w4a8_stream_mac;
  localparam int L = 8, K = 16, W = 16, KW = 16, OW = 32;
  localparam int AW = 8*K, WWID = 4*L*K, DW = W*L;

  logic            aclk = 1'b0, areset_n = 1'b1;
  logic            ctrl_start = 1'b0, ctrl_saturate = 1'b0;
  logic [KW-1:0]   ctrl_k_beats = '0;
  logic [OW-1:0]   ctrl_num_outputs = '0;
  logic            ctrl_done, ctrl_busy;
  logic            s_act_tvalid = 1'b0, s_act_tready;
  logic [AW-1:0]   s_act_tdata = '0;
  logic            s_wgt_tvalid = 1'b0, s_wgt_tready;
  logic [WWID-1:0] s_wgt_tdata = '0;
  logic            m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;

  int checks = 0, errors = 0, done_cnt = 0, out_cnt = 0;
  logic [DW-1:0] exp_data_q[$];
  bit            exp_last_q[$];
  bit rand_ready = 0, rand_gaps = 0, zero_done_exp = 0;

  // Narrow accumulators so saturation is reachable in a few beats.
  w4a8_stream_mac #(.C_LANES(L), .C_K_PAR(K), .C_ACC_WIDTH(W),
                    .C_KCNT_WIDTH(KW), .C_OCNT_WIDTH(OW)) dut (
    .aclk(aclk), .areset_n(areset_n), .ctrl_start(ctrl_start), .ctrl_k_beats(ctrl_k_beats),
    .ctrl_num_outputs(ctrl_num_outputs), .ctrl_saturate(ctrl_saturate), .ctrl_done(ctrl_done),
    .ctrl_busy(ctrl_busy), .s_act_tvalid(s_act_tvalid), .s_act_tready(s_act_tready),
    .s_act_tdata(s_act_tdata), .s_wgt_tvalid(s_wgt_tvalid), .s_wgt_tready(s_wgt_tready),
    .s_wgt_tdata(s_wgt_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast));

  initial forever #5 aclk = ~aclk;

  initial forever begin
    @(posedge aclk); #1;
    m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  function automatic longint fit(input longint v, input bit sat);
    longint span, maxv, minv;
    span = longint'(1) <<< W;
    maxv = span / 2 - 1;
    minv = -(span / 2);
    if (sat) return (v > maxv) ? maxv : ((v < minv) ? minv : v);
    v = v % span;
    if (v > maxv) v -= span;
    else if (v < minv) v += span;
    return v;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin : monitor
    logic [DW-1:0] prev_data, ed;
    bit prev_last, prev_stall, last_hs_prev, done_exp, el;
    prev_stall = 0; last_hs_prev = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        prev_stall = 0;
        last_hs_prev = 0;
      end else begin
        done_exp = last_hs_prev || zero_done_exp;
        if (ctrl_done) done_cnt++;
        if (done_exp || ctrl_done) begin
          checks++;
          if (ctrl_done !== done_exp) begin
            errors++;
            $display("FAIL done_pulse got %0b expected %0b", ctrl_done, done_exp);
          end
        end
        if (prev_stall) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
            errors++;
            $display("FAIL stall_hold got v=%0b last=%0b data=%h expected v=1 last=%0b data=%h",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, prev_last, prev_data);
          end
        end
        last_hs_prev = 0;
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_data_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got data=%h expected no beat", m_axis_tdata);
          end else begin
            ed = exp_data_q.pop_front();
            el = exp_last_q.pop_front();
            if (m_axis_tdata !== ed || m_axis_tlast !== el) begin
              errors++;
              $display("FAIL out_beat got data=%h last=%0b expected data=%h last=%0b",
                       m_axis_tdata, m_axis_tlast, ed, el);
            end
            $display("OUT beat %0d last=%0b data=%h", out_cnt, m_axis_tlast, m_axis_tdata);
            out_cnt++;
            last_hs_prev = el;
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic send_beat(input logic [AW-1:0] a, input logic [WWID-1:0] w);
    int waited;
    if (rand_gaps) begin
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      if ($urandom_range(0, 3) == 0) begin
        s_act_tvalid = 1'b1; s_act_tdata = a;
        @(posedge aclk); #1;
      end
    end
    s_act_tvalid = 1'b1; s_wgt_tvalid = 1'b1; s_act_tdata = a; s_wgt_tdata = w;
    waited = 0;
    forever begin
      @(negedge aclk);
      if (s_act_tready && s_wgt_tready) break;
      waited++;
      if (waited > 1000) begin
        checks++; errors++;
        $display("FAIL beat_accept timeout got no ready expected ready");
        break;
      end
    end
    @(posedge aclk); #1;
    s_act_tvalid = 1'b0; s_wgt_tvalid = 1'b0;
  endtask

  task automatic start_job(input int kb, input int no, input bit sat);
    ctrl_k_beats = KW'(kb); ctrl_num_outputs = OW'(no); ctrl_saturate = sat; ctrl_start = 1'b1;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
    zero_done_exp = (no == 0);
    @(negedge aclk);
    check("start_busy", ctrl_busy, (no > 0) ? 1 : 0);
    check("start_ready", s_act_tready, (no > 0) ? 1 : 0);
    @(posedge aclk); #1;
    zero_done_exp = 0;
  endtask

  task automatic wait_end(input int dc0);
    int n;
    n = 0;
    while (!(exp_data_q.size() == 0 && done_cnt > dc0)) begin
      @(negedge aclk);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL job_end timeout got pending=%0d expected 0", exp_data_q.size());
        break;
      end
    end
    @(posedge aclk); #1;
  endtask

  // mode 0: random data, 1: constant act/wgt, 2: act[k]=k and lane l weight = l-4
  task automatic run_job(input int kb, input int no, input bit sat, input int mode,
                         input int ca, input int cw, input bit glitch, input bit lat);
    int kbe, dc0, dot;
    longint acc[L];
    int act[K];
    int wgt[L][K];
    logic [AW-1:0] a;
    logic [WWID-1:0] w;
    logic [DW-1:0] d;
    kbe = (kb == 0) ? 1 : kb;
    dc0 = done_cnt;
    start_job(kb, no, sat);
    for (int o = 0; o < no; o++) begin
      foreach (acc[l]) acc[l] = 0;
      for (int b = 0; b < kbe; b++) begin
        for (int k = 0; k < K; k++) begin
          act[k] = (mode == 1) ? ca : (mode == 2) ? k : int'($urandom_range(0, 255)) - 128;
          a[8*k +: 8] = act[k][7:0];
          for (int l = 0; l < L; l++) begin
            wgt[l][k] = (mode == 1) ? cw : (mode == 2) ? l - 4 : int'($urandom_range(0, 15)) - 8;
            w[4*(l*K+k) +: 4] = wgt[l][k][3:0];
          end
        end
        for (int l = 0; l < L; l++) begin
          dot = 0;
          for (int k = 0; k < K; k++) dot += act[k] * wgt[l][k];
          acc[l] = fit(acc[l] + longint'(dot), sat);
        end
        send_beat(a, w);
        if (glitch && o == 0 && b == 0) begin
          ctrl_k_beats = 1; ctrl_num_outputs = 7; ctrl_saturate = !sat; ctrl_start = 1'b1;
          @(posedge aclk); #1;
          ctrl_start = 1'b0;
          @(negedge aclk);
          check("glitch_busy", ctrl_busy, 1);
          @(posedge aclk); #1;
        end
      end
      for (int l = 0; l < L; l++) d[W*l +: W] = acc[l][W-1:0];
      exp_data_q.push_back(d);
      exp_last_q.push_back(o == no - 1);
      if (lat) begin
        @(negedge aclk);
        check("latency_t1", m_axis_tvalid, 0);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("latency_t2", m_axis_tvalid, 1);
        @(posedge aclk); #1;
      end
    end
    wait_end(dc0);
    check("job_end_idle", ctrl_busy, 0);
  endtask

  initial begin : stim
    logic [AW-1:0] a;
    logic [WWID-1:0] w;
    #2 areset_n = 1'b0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tready", {s_act_tready, s_wgt_tready}, 0);
    check("rst_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
    check("rst_ctrl", {ctrl_done, ctrl_busy, m_axis_tlast}, 0);
    repeat (3) @(posedge aclk);
    #3 areset_n = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("idle_tready", s_act_tready, 0);
    @(posedge aclk); #1;

    // basic: 16 x 3 x -2 = -96 per lane, with first-beat latency
    run_job(1, 1, 0, 1, 3, -2, 0, 1);
    // accumulate with an ignored start pulse mid-job
    run_job(4, 2, 0, 2, 0, 0, 1, 0);
    // saturation vs wrap at 16-bit accumulators
    run_job(4, 1, 1, 1, -128, -8, 0, 0);
    run_job(4, 1, 0, 1, -128, -8, 0, 0);
    // back-pressure with random input gaps
    rand_ready = 1; rand_gaps = 1;
    run_job(1, 8, 0, 0, 0, 0, 0, 0);
    run_job(3, 5, 1, 0, 0, 0, 0, 0);
    rand_ready = 0; rand_gaps = 0;
    // edge configs
    run_job(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge aclk);
    check("zero_job_ready", s_act_tready, 0);
    @(posedge aclk); #1;
    run_job(0, 3, 0, 0, 0, 0, 0, 0);

    // reset in the middle of a group
    start_job(4, 2, 0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < AW / 32; i++) a[32*i +: 32] = $urandom;
      for (int i = 0; i < WWID / 32; i++) w[32*i +: 32] = $urandom;
      send_beat(a, w);
    end
    #2 areset_n = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tready", {s_act_tready, s_wgt_tready}, 0);
    check("midrst_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
    check("midrst_ctrl", {ctrl_done, ctrl_busy, m_axis_tlast}, 0);
    exp_data_q.delete();
    exp_last_q.delete();
    repeat (2) @(posedge aclk);
    #3 areset_n = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      check("post_rst_idle", {s_act_tready, ctrl_busy, ctrl_done}, 0);
    end
    @(posedge aclk); #1;
    run_job(2, 2, 0, 0, 0, 0, 0, 0);
    run_job(1, 4, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
